pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Drives write-enables for the PC and IF/ID, a bubble-insert (flush) for IF/ID and ID/EX, and a global hold for ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and taken-branch redirects.
- Freezes the pipeline while data memory is not ready, with a timeout watchdog and a saturating stall counter.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before error (≥2).
- WAIT_W, 8, width of wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.
- COUNT_W, 32, width of Stall_Count.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- MemRead_EX  in  1  instruction in EX is a load
- Write_Register_EX  in  5  destination register of EX instruction
- Rs_ID  in  5  rs of instruction in ID
- Rt_ID  in  5  rt of instruction in ID
- Uses_Rt_ID  in  1  ID instruction reads rt as a source
- Branch_Taken_EX  in  1  branch/jump in EX resolved taken
- Mem_Req_MEM  in  1  instruction in MEM accesses data memory
- Mem_Ready  in  1  data memory completes access this cycle
- PC_Write  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID load enable
- IF_ID_Flush  out  1  IF/ID loads NOP
- ID_EX_Flush  out  1  ID/EX loads bubble (all control zero)
- Pipe_Hold  out  1  ID/EX, EX/MEM, MEM/WB hold contents
- Mem_Error  out  1  sticky memory-timeout flag
- Stall_Count  out  COUNT_W  cycles with PC_Write=0 since reset, saturating

Behaviour:
- State register, 3 states: RUN, MEM_WAIT, ERROR. Outputs are combinational from state + inputs; state, counters and Mem_Error are registered.
- Reset (sampled at posedge) → state=RUN, wait_cnt=0, Stall_Count=0, Mem_Error=0. Reset dominates all other events, including mid-MEM_WAIT and ERROR.
- While Reset=1, outputs are forced: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Hold=0.
- mem_stall = Mem_Req_MEM & ~Mem_Ready.
- load_use = MemRead_EX & (Write_Register_EX != 0) & ((Write_Register_EX == Rs_ID) | (Uses_Rt_ID & Write_Register_EX == Rt_ID)).
- Default output (no event): PC_Write=1, IF_ID_Write=1, flushes=0, Pipe_Hold=0.
- RUN/MEM_WAIT priority, highest first:
  1. mem_stall: PC_Write=0, IF_ID_Write=0, Pipe_Hold=1, flushes=0. Suppresses any branch flush or load-use action this cycle; the branch/load stay in place and are re-evaluated next cycle.
  2. Branch_Taken_EX: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1. Branch wins over load_use because the dependent instruction is discarded.
  3. load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, Pipe_Hold=0. This is exactly one bubble; the hazard clears naturally next cycle.
- RUN transitions: mem_stall → MEM_WAIT with wait_cnt=1; otherwise stay in RUN.
- MEM_WAIT transitions:
  - Each cycle, outputs follow the priority above.
  - Mem_Ready=1 (or Mem_Req_MEM=0) → go to RUN, wait_cnt=0. The pipeline advances in that same cycle (0 extra latency).
  - Still mem_stall and wait_cnt == MEM_TIMEOUT-1 → go to ERROR, Mem_Error=1.
  - Otherwise wait_cnt++.
- ERROR: PC_Write=0, IF_ID_Write=0, flushes=0, Pipe_Hold=1 regardless of inputs. Exit only via Reset.
- Stall_Count increments at each posedge (Reset=0) where PC_Write was 0 in that cycle, including ERROR. It saturates at all-ones and never wraps.
- A Mem_Ready pulse without Mem_Req_MEM is ignored.

Test Plan:
- Load-use: MemRead_EX=1, Write_Register_EX=8, Rs_ID=8, no mem req → one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead_EX=0) all defaults; Stall_Count=1.
- Rt filter and $zero: Write_Register_EX=9, Rt_ID=9, Uses_Rt_ID=0 → no stall; Write_Register_EX=0, Rs_ID=0 → no stall; Uses_Rt_ID=1 with Rt_ID=9 → stall.
- Branch vs load-use: Branch_Taken_EX=1 and load_use=1 simultaneously → IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; Stall_Count unchanged.
- Memory wait: Mem_Req_MEM=1, Mem_Ready low for 3 cycles then high → Pipe_Hold=1 for 3 cycles, released in the Mem_Ready cycle; state back to RUN; Stall_Count=3. A Branch_Taken_EX held during the wait flushes only in the release cycle.
- Timeout: MEM_TIMEOUT=4, Mem_Ready held low → ERROR entered after cycle 4 with Mem_Error=1 and outputs frozen; assert Reset for one cycle → RUN, Mem_Error=0, Stall_Count=0.
- Saturation: COUNT_W=3, force 10 stall cycles → Stall_Count stops at 7; Reset asserted mid-MEM_WAIT → RUN next cycle, with forced reset outputs while Reset is high.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for load-use, taken branches and data-memory waits
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 8,
  parameter int COUNT_W     = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               MemRead_EX,
  input  logic [4:0]         Write_Register_EX,
  input  logic [4:0]         Rs_ID,
  input  logic [4:0]         Rt_ID,
  input  logic               Uses_Rt_ID,
  input  logic               Branch_Taken_EX,
  input  logic               Mem_Req_MEM,
  input  logic               Mem_Ready,
  output logic               PC_Write,
  output logic               IF_ID_Write,
  output logic               IF_ID_Flush,
  output logic               ID_EX_Flush,
  output logic               Pipe_Hold,
  output logic               Mem_Error,
  output logic [COUNT_W-1:0] Stall_Count
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [COUNT_W-1:0] r_stall_cnt;
  logic               r_mem_error;
  logic               w_mem_stall, w_load_use, w_freeze, w_advance;
  assign w_mem_stall = Mem_Req_MEM & ~Mem_Ready;
  assign w_load_use  = MemRead_EX & (Write_Register_EX != 5'd0) &
                       ((Write_Register_EX == Rs_ID) | (Uses_Rt_ID & (Write_Register_EX == Rt_ID)));
  // a freeze (memory wait or error) masks both branch flush and load-use bubble
  assign w_freeze    = (r_state == ERROR) | w_mem_stall;
  assign w_advance   = ~Reset & ~w_freeze & (Branch_Taken_EX | ~w_load_use);
  assign PC_Write    = w_advance;
  assign IF_ID_Write = w_advance;
  assign IF_ID_Flush = Reset | (~w_freeze & Branch_Taken_EX);
  assign ID_EX_Flush = Reset | (~w_freeze & (Branch_Taken_EX | w_load_use));
  assign Pipe_Hold   = ~Reset & w_freeze;
  assign Mem_Error   = r_mem_error;
  assign Stall_Count = r_stall_cnt;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_mem_error <= 1'b0;
    end else begin
      if (!PC_Write && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + COUNT_W'(1);
      case (r_state)
        RUN: if (w_mem_stall) begin
          r_state    <= MEM_WAIT;
          r_wait_cnt <= WAIT_W'(1);
        end
        MEM_WAIT: if (!w_mem_stall) begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          r_state     <= ERROR;
          r_mem_error <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
        ERROR: r_state <= ERROR;
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors with hand-computed expectations
module tb_pipeline_hazard_controller;
  localparam int COUNT_W = 3;
  localparam logic [4:0] DEF = 5'b11000, STL = 5'b00001, BRF = 5'b11110, LUB = 5'b00010, RST = 5'b00110;
  logic Clk = 1'b0, Reset, MemRead_EX, Uses_Rt_ID, Branch_Taken_EX, Mem_Req_MEM, Mem_Ready;
  logic [4:0] Write_Register_EX, Rs_ID, Rt_ID;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, Mem_Error;
  logic [COUNT_W-1:0] Stall_Count;
  logic [4:0] outs;
  int n_vec = 0, n_err = 0;
  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .WAIT_W(4), .COUNT_W(COUNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX), .Write_Register_EX(Write_Register_EX),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Uses_Rt_ID(Uses_Rt_ID), .Branch_Taken_EX(Branch_Taken_EX),
    .Mem_Req_MEM(Mem_Req_MEM), .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Pipe_Hold(Pipe_Hold),
    .Mem_Error(Mem_Error), .Stall_Count(Stall_Count)
  );
  always #5 Clk = ~Clk;
  assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic idle;
    {MemRead_EX, Uses_Rt_ID, Branch_Taken_EX, Mem_Req_MEM, Mem_Ready} = '0;
    {Write_Register_EX, Rs_ID, Rt_ID} = '0;
  endtask
  task automatic do_reset;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
  endtask
  initial begin
    idle();
    Reset = 1'b1;
    #1 check("reset_outs", 32'(outs), 32'(RST));
    tick(); tick();
    Reset = 1'b0;
    #1;
    check("post_reset_outs", 32'(outs), 32'(DEF));
    check("post_reset_cnt", 32'(Stall_Count), 0);
    check("post_reset_err", 32'(Mem_Error), 0);
    // load-use on rs
    MemRead_EX = 1'b1; Write_Register_EX = 5'd8; Rs_ID = 5'd8;
    #1 check("lu_rs_outs", 32'(outs), 32'(LUB));
    tick();
    MemRead_EX = 1'b0;
    #1 check("lu_next_outs", 32'(outs), 32'(DEF));
    check("lu_cnt", 32'(Stall_Count), 1);
    // rt filter and $zero
    MemRead_EX = 1'b1; Write_Register_EX = 5'd9; Rs_ID = 5'd3; Rt_ID = 5'd9; Uses_Rt_ID = 1'b0;
    #1 check("rt_unused_outs", 32'(outs), 32'(DEF));
    Write_Register_EX = 5'd0; Rs_ID = 5'd0;
    #1 check("zero_reg_outs", 32'(outs), 32'(DEF));
    Write_Register_EX = 5'd9; Rs_ID = 5'd3; Uses_Rt_ID = 1'b1;
    #1 check("rt_used_outs", 32'(outs), 32'(LUB));
    tick();
    check("rt_used_cnt", 32'(Stall_Count), 2);
    // branch beats load-use
    Branch_Taken_EX = 1'b1;
    #1 check("br_vs_lu_outs", 32'(outs), 32'(BRF));
    tick();
    check("br_vs_lu_cnt", 32'(Stall_Count), 2);
    // memory wait with branch held throughout
    idle();
    do_reset();
    Mem_Req_MEM = 1'b1; Branch_Taken_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("memwait_outs%0d", i), 32'(outs), 32'(STL));
      tick();
    end
    Mem_Ready = 1'b1;
    #1 check("release_outs", 32'(outs), 32'(BRF));
    tick();
    check("release_cnt", 32'(Stall_Count), 3);
    idle(); Mem_Ready = 1'b1;
    #1 check("ready_no_req_outs", 32'(outs), 32'(DEF));
    tick();
    check("ready_no_req_cnt", 32'(Stall_Count), 3);
    check("release_err", 32'(Mem_Error), 0);
    // timeout to ERROR
    idle();
    do_reset();
    Mem_Req_MEM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("to_outs%0d", i), 32'(outs), 32'(STL));
      check($sformatf("to_err_pre%0d", i), 32'(Mem_Error), 0);
      tick();
    end
    check("to_err", 32'(Mem_Error), 1);
    check("to_cnt", 32'(Stall_Count), 4);
    Mem_Req_MEM = 1'b0; Mem_Ready = 1'b1; Branch_Taken_EX = 1'b1;
    #1 check("error_frozen_outs", 32'(outs), 32'(STL));
    tick();
    check("error_cnt", 32'(Stall_Count), 5);
    check("error_sticky", 32'(Mem_Error), 1);
    Reset = 1'b1;
    #1 check("error_reset_outs", 32'(outs), 32'(RST));
    tick();
    Reset = 1'b0; idle();
    #1 check("after_err_reset_outs", 32'(outs), 32'(DEF));
    check("after_err_reset_err", 32'(Mem_Error), 0);
    check("after_err_reset_cnt", 32'(Stall_Count), 0);
    // saturation
    Mem_Req_MEM = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("sat_cnt7", 32'(Stall_Count), 7);
    for (int i = 0; i < 3; i++) tick();
    check("sat_cnt10", 32'(Stall_Count), 7);
    // reset in the middle of MEM_WAIT
    idle();
    do_reset();
    Mem_Req_MEM = 1'b1;
    tick(); tick();
    Reset = 1'b1;
    #1 check("midwait_reset_outs", 32'(outs), 32'(RST));
    tick();
    Reset = 1'b0; Mem_Req_MEM = 1'b0;
    #1 check("midwait_after_outs", 32'(outs), 32'(DEF));
    check("midwait_after_cnt", 32'(Stall_Count), 0);
    Mem_Req_MEM = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("midwait_rewait_err", 32'(Mem_Error), 0);
    tick();
    check("midwait_timeout_err", 32'(Mem_Error), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
